// File: rtl/fpu_pkg.sv
// fpu_pkg: shared types and constants for the FP multiply scheduling slice.
//   FLOAT_W   - IEEE-754 single operand/result width
//   FMUL_LAT  - issue-to-result latency of the shared fmul datapath
//   float_t   - raw single-precision bit pattern (never interpreted here)
//   tag_t     - {valid, idx} record that travels alongside an in-flight op
//   idx_w()   - index width for a given requester count
package fpu_pkg;

  localparam int FLOAT_W   = 32;
  localparam int FMUL_LAT  = 8;
  // Requester counts are capped at 8, so a 3-bit index always fits.
  localparam int MAX_IDX_W = 3;

  typedef logic [FLOAT_W-1:0] float_t;

  typedef struct packed {
    logic                 valid;
    logic [MAX_IDX_W-1:0] idx;
  } tag_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fmul_sched_if.sv
// fmul_sched_if: requester-side bundle of the shared-multiplier scheduler.
//   req_valid/req_ready  - per-lane issue handshake
//   req_x1/req_x2        - per-lane operands, lane i at [i*W +: W]
//   rsp_valid/rsp_ready  - per-lane result handshake
//   rsp_y                - per-lane result, same packing
// Handshake rule (both directions): a transfer happens on a rising clk edge
// exactly when valid && ready are both high for that lane. req_ready is a
// combinational grant and may depend on req_valid; rsp_valid never depends on
// rsp_ready and, once high, holds with stable data until the transfer.
// modport master = FPU issue slots, modport slave = scheduler.
interface fmul_sched_if
  import fpu_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int W    = FLOAT_W
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_x1;
  logic [NREQ*W-1:0] req_x2;
  logic [NREQ-1:0]   rsp_valid;
  logic [NREQ-1:0]   rsp_ready;
  logic [NREQ*W-1:0] rsp_y;

  modport master (
    output req_valid, req_x1, req_x2, rsp_ready,
    input  req_ready, rsp_valid, rsp_y
  );

  modport slave (
    input  req_valid, req_x1, req_x2, rsp_ready,
    output req_ready, rsp_valid, rsp_y
  );
endinterface

// File: rtl/fmul_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker.
//   eligible  - lanes that may be granted this cycle
//   ptr       - lane with highest priority this cycle
//   grant     - one-hot (or zero) winner: first eligible lane at or after ptr,
//               searching upward and wrapping N-1 -> 0
//   next_ptr  - lane after the winner; equals ptr when nothing is granted
module rr_arbiter #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] next_ptr
);

  int   j;
  logic found;

  always_comb begin
    grant    = '0;
    next_ptr = ptr;
    found    = 1'b0;
    j        = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!found && eligible[j]) begin
        found    = 1'b1;
        grant[j] = 1'b1;
        next_ptr = IW'((j + 1) % N);
      end
    end
  end

endmodule

// File: rtl/fmul_sched.sv
// fmul_sched: shares one fixed-latency pipelined fmul between NREQ issue slots.
//   clk, rst    - clock; synchronous active-high reset
//   bus         - requester handshakes and operands/results (fmul_sched_if.slave)
//   fmul_issue  - an operation is presented to the multiplier this cycle
//   fmul_x1/x2  - operands of the granted lane (0 when nothing is granted)
//   fmul_y      - multiplier result, valid exactly LAT cycles after issue
//   idle        - nothing in flight and no result waiting to be consumed
// Each lane may have one operation outstanding (busy flag), which is what
// keeps a returning result from ever landing on an occupied response slot.
module fmul_sched
  import fpu_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int LAT  = FMUL_LAT,
  parameter int W    = FLOAT_W
) (
  input  logic         clk,
  input  logic         rst,
  fmul_sched_if.slave  bus,
  output logic         fmul_issue,
  output logic [W-1:0] fmul_x1,
  output logic [W-1:0] fmul_x2,
  input  logic [W-1:0] fmul_y,
  output logic         idle
);

  localparam int IW = idx_w(NREQ);

  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   next_ptr;
  logic [NREQ-1:0] busy_q;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  logic [IW-1:0]   grant_idx;
  logic [NREQ-1:0] capture;
  logic [NREQ-1:0] rsp_fire;
  logic [NREQ-1:0] rsp_valid_q;
  logic [W-1:0]    rsp_y_q [NREQ];
  tag_t            tag_q   [LAT];

  // Reset gates eligibility so no grant leaks out while rst is high.
  assign eligible = bus.req_valid & ~busy_q & {NREQ{~rst}};

  rr_arbiter #(.N(NREQ), .IW(IW)) u_arb (
    .eligible (eligible),
    .ptr      (ptr_q),
    .grant    (grant),
    .next_ptr (next_ptr)
  );

  assign bus.req_ready = grant;
  assign fmul_issue    = |grant;
  assign rsp_fire      = rsp_valid_q & bus.rsp_ready;
  assign idle          = rst | ~(|busy_q);

  always_comb begin
    fmul_x1   = '0;
    fmul_x2   = '0;
    grant_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        fmul_x1   = bus.req_x1[i*W +: W];
        fmul_x2   = bus.req_x2[i*W +: W];
        grant_idx = IW'(i);
      end
    end
  end

  // The oldest tag lines up with fmul_y; it names the lane to capture into.
  always_comb begin
    capture = '0;
    for (int i = 0; i < NREQ; i++) begin
      capture[i] = tag_q[LAT-1].valid && (tag_q[LAT-1].idx == MAX_IDX_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q  <= '0;
      busy_q <= '0;
    end else begin
      if (fmul_issue) begin
        ptr_q <= next_ptr;
      end
      // Clearing on the handshake edge makes the lane eligible one cycle
      // after consumption, never in the handshake cycle itself.
      busy_q <= (busy_q & ~rsp_fire) | grant;
    end
  end

  // Tag pipeline: never stalls, mirrors the multiplier's fixed latency.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < LAT; s++) begin
        tag_q[s] <= '0;
      end
    end else begin
      tag_q[0].valid <= fmul_issue;
      tag_q[0].idx   <= MAX_IDX_W'(grant_idx);
      for (int s = 1; s < LAT; s++) begin
        tag_q[s] <= tag_q[s-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_q <= '0;
      for (int i = 0; i < NREQ; i++) begin
        rsp_y_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        if (capture[i]) begin
          rsp_valid_q[i] <= 1'b1;
          rsp_y_q[i]     <= fmul_y;
        end else if (rsp_fire[i]) begin
          // rsp_y keeps its last value after consumption.
          rsp_valid_q[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.rsp_valid = rsp_valid_q;

  for (genvar g = 0; g < NREQ; g++) begin : g_rsp_pack
    assign bus.rsp_y[g*W +: W] = rsp_y_q[g];
  end

endmodule

// File: tb/tb_fmul_sched.sv
// tb_fmul_sched: directed bench for fmul_sched with a behavioural LAT-cycle
// multiplier, a per-cycle monitor/scoreboard and hand-written corner cases.
module tb_fmul_sched;

  localparam int NREQ = 4;
  localparam int LAT  = 8;
  localparam int W    = 32;

  typedef struct {
    int          lane;
    logic [31:0] x1;
    logic [31:0] x2;
    logic [31:0] y;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         rst;
  logic         fmul_issue;
  logic [W-1:0] fmul_x1;
  logic [W-1:0] fmul_x2;
  logic [W-1:0] fmul_y;
  logic         idle;

  always #5 clk = ~clk;

  fmul_sched_if #(.NREQ(NREQ), .W(W)) bus ();

  fmul_sched #(.NREQ(NREQ), .LAT(LAT), .W(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .fmul_issue (fmul_issue),
    .fmul_x1    (fmul_x1),
    .fmul_x2    (fmul_x2),
    .fmul_y     (fmul_y),
    .idle       (idle)
  );

  logic [W-1:0] drv_x1  [NREQ];
  logic [W-1:0] drv_x2  [NREQ];
  logic [W-1:0] drv_exp [NREQ];

  always_comb begin
    bus.req_x1 = '0;
    bus.req_x2 = '0;
    for (int i = 0; i < NREQ; i++) begin
      bus.req_x1[i*W +: W] = drv_x1[i];
      bus.req_x2[i*W +: W] = drv_x2[i];
    end
  end

  // ---------------- multiplier model ----------------
  function automatic logic [63:0] s2d(input logic [31:0] s);
    logic [10:0] e;
    e = {3'b000, s[30:23]} + 11'd896;
    return {s[31], e, s[22:0], 29'b0};
  endfunction

  function automatic logic [31:0] d2s(input logic [63:0] d);
    logic [10:0] e;
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fmul_model(input logic [31:0] a, input logic [31:0] b);
    real ra;
    real rb;
    ra = $bitstoreal(s2d(a));
    rb = $bitstoreal(s2d(b));
    return d2s($realtobits(ra * rb));
  endfunction

  function automatic logic [1:0] enc(input logic [NREQ-1:0] v);
    logic [1:0] r;
    r = '0;
    for (int i = 0; i < NREQ; i++) if (v[i]) r = 2'(i);
    return r;
  endfunction

  logic         mp_v    [LAT];
  logic [W-1:0] mp_y    [LAT];
  logic [1:0]   mp_lane [LAT];

  always @(posedge clk) begin
    mp_v[0]    <= fmul_issue;
    mp_y[0]    <= fmul_issue ? fmul_model(fmul_x1, fmul_x2) : 32'hDEADBEEF;
    mp_lane[0] <= enc(bus.req_ready);
    for (int s = 1; s < LAT; s++) begin
      mp_v[s]    <= mp_v[s-1];
      mp_y[s]    <= mp_y[s-1];
      mp_lane[s] <= mp_lane[s-1];
    end
  end

  assign fmul_y = mp_v[LAT-1] ? mp_y[LAT-1] : 32'hDEADBEEF;

  // ---------------- scoreboard state ----------------
  int           n_checks = 0;
  int           n_pass   = 0;
  int           cyc      = 0;
  logic [W-1:0] exp_q [$];
  int           lane_q [$];
  int           cyc_q  [$];
  int           gl_lane [$];
  int           gl_cyc  [$];
  logic [NREQ-1:0] pend;
  logic [NREQ-1:0] prev_v;
  logic [NREQ-1:0] prev_hs;
  logic [NREQ-1:0] granted_last;
  logic [W-1:0]    prev_y [NREQ];
  logic            auto_drop;
  vec_t            tbl [6];

  function automatic logic [W-1:0] lane_y(input int i);
    return bus.rsp_y[i*W +: W];
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, want, cyc);
  endtask

  task automatic clear_sb();
    exp_q.delete();
    lane_q.delete();
    cyc_q.delete();
    gl_lane.delete();
    gl_cyc.delete();
    pend         = '0;
    prev_v       = '0;
    prev_hs      = '0;
    granted_last = '0;
  endtask

  task automatic monitor();
    granted_last = '0;
    check("grant_onehot", 64'($onehot0(bus.req_ready)), 1);
    for (int i = 0; i < NREQ; i++) begin
      if (bus.req_ready[i]) begin
        check("ready_needs_valid", bus.req_valid[i], 1);
        check("issue_flag", fmul_issue, 1);
        check("issue_x1", fmul_x1, drv_x1[i]);
        check("issue_x2", fmul_x2, drv_x2[i]);
        check("no_grant_while_pending", pend[i], 0);
        pend[i] = 1'b1;
        exp_q.push_back(drv_exp[i]);
        lane_q.push_back(i);
        cyc_q.push_back(cyc);
        gl_lane.push_back(i);
        gl_cyc.push_back(cyc);
        granted_last[i] = 1'b1;
      end
    end
    if (mp_v[LAT-1]) check("capture_slot_free", bus.rsp_valid[mp_lane[LAT-1]], 0);
    for (int i = 0; i < NREQ; i++) begin
      if (bus.rsp_valid[i] && !prev_v[i]) begin
        if (exp_q.size() == 0) check("unexpected_rsp", 1, 0);
        else begin
          logic [W-1:0] e;
          int           l;
          int           c;
          e = exp_q.pop_front();
          l = lane_q.pop_front();
          c = cyc_q.pop_front();
          check("rsp_lane", i, l);
          check("rsp_y", lane_y(i), e);
          check("rsp_latency", cyc - c, LAT + 1);
        end
      end else if (bus.rsp_valid[i] && prev_v[i]) begin
        check("rsp_y_held", lane_y(i), prev_y[i]);
      end
      if (prev_hs[i]) check("rsp_drop_after_hs", bus.rsp_valid[i], 0);
      prev_hs[i] = bus.rsp_valid[i] && bus.rsp_ready[i];
      if (prev_hs[i]) pend[i] = 1'b0;
      prev_v[i] = bus.rsp_valid[i];
      prev_y[i] = lane_y(i);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic sample();
    @(negedge clk);
    monitor();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
    cyc++;
    if (auto_drop) bus.req_valid = bus.req_valid & ~granted_last;
  endtask

  task automatic cycle();
    sample();
    adv();
  endtask

  task automatic set_lane(input int lane, input int k);
    drv_x1[lane]  = tbl[k].x1;
    drv_x2[lane]  = tbl[k].x2;
    drv_exp[lane] = tbl[k].y;
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.req_valid = '0;
    clear_sb();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    cyc = 0;
  endtask

  task automatic wait_idle(input int budget);
    logic done;
    done = 1'b0;
    for (int k = 0; k < budget; k++) begin
      sample();
      done = idle && (bus.rsp_valid == '0) && (exp_q.size() == 0);
      adv();
      if (done) break;
    end
    check("wait_idle_timeout", done, 1);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    tbl[0] = '{0, 32'h3F800000, 32'h40000000, 32'h40000000};  // 1.0 * 2.0
    tbl[1] = '{1, 32'h40400000, 32'h40800000, 32'h41400000};  // 3 * 4
    tbl[2] = '{2, 32'h3FC00000, 32'h40000000, 32'h40400000};  // 1.5 * 2
    tbl[3] = '{3, 32'hC0000000, 32'h40A00000, 32'hC1200000};  // -2 * 5
    tbl[4] = '{2, 32'h3F000000, 32'h41000000, 32'h40800000};  // 0.5 * 8
    tbl[5] = '{0, 32'h40E00000, 32'h40C00000, 32'h42280000};  // 7 * 6

    auto_drop     = 1'b1;
    bus.rsp_ready = '1;
    for (int i = 0; i < NREQ; i++) set_lane(i, i);
    clear_sb();

    // Reset state with every lane requesting.
    rst           = 1'b1;
    bus.req_valid = '1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("rst_req_ready", bus.req_ready, 0);
    check("rst_fmul_issue", fmul_issue, 0);
    check("rst_fmul_x1", fmul_x1, 0);
    check("rst_fmul_x2", fmul_x2, 0);
    check("rst_idle", idle, 1);
    check("rst_rsp_valid", bus.rsp_valid, 0);
    check("rst_rsp_y", bus.rsp_y, 0);
    do_reset();

    // Single request on lane 0.
    set_lane(0, 0);
    bus.req_valid = 4'b0001;
    sample();
    check("t1_req_ready", bus.req_ready, 4'b0001);
    check("t1_fmul_x1", fmul_x1, 32'h3F800000);
    check("t1_fmul_x2", fmul_x2, 32'h40000000);
    adv();
    while (cyc < 8) cycle();
    sample();
    check("t1_rsp_not_early", bus.rsp_valid, 0);
    adv();
    sample();
    check("t1_rsp_valid_c9", bus.rsp_valid, 4'b0001);
    check("t1_rsp_y", lane_y(0), 32'h40000000);
    adv();
    sample();
    check("t1_rsp_dropped", bus.rsp_valid, 0);
    check("t1_rsp_y_kept", lane_y(0), 32'h40000000);
    check("t1_idle", idle, 1);
    adv();

    // Table vectors, one at a time.
    for (int k = 0; k < 6; k++) begin
      logic got_g;
      logic got_r;
      set_lane(tbl[k].lane, k);
      bus.req_valid[tbl[k].lane] = 1'b1;
      got_g = 1'b0;
      for (int c = 0; c < 10 && !got_g; c++) begin
        sample();
        got_g = bus.req_ready[tbl[k].lane];
        adv();
      end
      check("tbl_grant", got_g, 1);
      got_r = 1'b0;
      for (int c = 0; c < 2 * LAT && !got_r; c++) begin
        sample();
        if (bus.rsp_valid[tbl[k].lane]) begin
          check("tbl_y", lane_y(tbl[k].lane), tbl[k].y);
          got_r = 1'b1;
        end
        adv();
      end
      check("tbl_rsp_seen", got_r, 1);
    end
    wait_idle(20);

    // All four lanes valid from reset.
    do_reset();
    for (int i = 0; i < NREQ; i++) set_lane(i, i);
    auto_drop     = 1'b0;
    bus.req_valid = '1;
    for (int c = 0; c < 9; c++) begin
      sample();
      if (c >= 4) check("t2_no_grant_all_busy", fmul_issue, 0);
      adv();
    end
    bus.req_valid = '0;
    auto_drop     = 1'b1;
    check("t2_grant_count", gl_lane.size(), 4);
    for (int k = 0; k < 4; k++) begin
      check("t2_grant_lane", gl_lane[k], k);
      check("t2_grant_cycle", gl_cyc[k], k);
    end
    wait_idle(20);

    // Round robin from ptr=2 with lanes 3,1,0 requesting.
    do_reset();
    set_lane(1, 1);
    bus.req_valid = 4'b0010;
    wait_idle(20);
    gl_lane.delete();
    gl_cyc.delete();
    set_lane(0, 0);
    set_lane(3, 3);
    bus.req_valid = 4'b1011;
    for (int c = 0; c < 3; c++) cycle();
    check("t3_grant_count", gl_lane.size(), 3);
    check("t3_first", gl_lane[0], 3);
    check("t3_wrap", gl_lane[1], 0);
    check("t3_third", gl_lane[2], 1);
    check("t3_back_to_back", gl_cyc[2] - gl_cyc[0], 2);
    wait_idle(20);

    // Back-pressure on lane 1.
    do_reset();
    set_lane(1, 1);
    auto_drop     = 1'b0;
    bus.rsp_ready = 4'b1101;
    bus.req_valid = 4'b0010;
    sample();
    check("t4_first_grant", bus.req_ready, 4'b0010);
    adv();
    for (int c = 1; c < 9; c++) begin
      sample();
      check("t4_busy_no_ready", bus.req_ready[1], 0);
      adv();
    end
    for (int c = 0; c < 20; c++) begin
      sample();
      check("t4_rsp_held", bus.rsp_valid[1], 1);
      check("t4_rsp_y", lane_y(1), 32'h41400000);
      check("t4_no_regrant", bus.req_ready[1], 0);
      adv();
    end
    bus.rsp_ready = '1;
    sample();
    check("t4_no_regrant_in_hs_cycle", bus.req_ready[1], 0);
    adv();
    sample();
    check("t4_regrant_after_hs", bus.req_ready[1], 1);
    check("t4_rsp_cleared", bus.rsp_valid[1], 0);
    adv();
    bus.req_valid = '0;
    auto_drop     = 1'b1;
    wait_idle(20);

    // Reset in the middle of two operations.
    do_reset();
    set_lane(0, 0);
    set_lane(2, 2);
    bus.req_valid = 4'b0101;
    while (cyc < 4) cycle();
    check("t5_two_issued", gl_lane.size(), 2);
    rst = 1'b1;
    clear_sb();
    bus.req_valid = 4'b0010;
    sample();
    check("t5_rst_idle", idle, 1);
    check("t5_rst_no_ready", bus.req_ready, 0);
    check("t5_rst_no_issue", fmul_issue, 0);
    adv();
    rst           = 1'b0;
    bus.req_valid = '0;
    while (cyc <= 20) begin
      sample();
      check("t5_no_stale_rsp", bus.rsp_valid, 0);
      check("t5_idle", idle, 1);
      adv();
    end
    set_lane(3, 3);
    bus.req_valid = 4'b1000;
    sample();
    check("t5_new_grant", bus.req_ready, 4'b1000);
    adv();
    while (cyc < 30) begin
      sample();
      check("t5_new_not_early", bus.rsp_valid[3], 0);
      adv();
    end
    sample();
    check("t5_new_rsp", bus.rsp_valid[3], 1);
    check("t5_new_y", lane_y(3), 32'hC1200000);
    adv();
    wait_idle(20);

    // Capture on lane 0, handshake on lane 3 and grant to lane 1 together.
    do_reset();
    set_lane(3, 3);
    set_lane(0, 5);
    set_lane(1, 1);
    bus.rsp_ready = 4'b0111;
    bus.req_valid = 4'b1000;
    while (cyc < 4) cycle();
    bus.req_valid = 4'b0001;
    while (cyc < 12) cycle();
    bus.rsp_ready = '1;
    bus.req_valid = 4'b0010;
    sample();
    check("t6_grant_lane1", bus.req_ready, 4'b0010);
    check("t6_only_lane3_held", bus.rsp_valid, 4'b1000);
    adv();
    sample();
    check("t6_after", bus.rsp_valid, 4'b0001);
    check("t6_lane0_y", lane_y(0), 32'h42280000);
    check("t6_lane3_y_kept", lane_y(3), 32'hC1200000);
    adv();
    wait_idle(20);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/fmul_sched.md
Name: fmul_sched

Overview:
Shares one fixed-latency pipelined single-precision multiplier (the team's fmul datapath) between NREQ independent requesters (FPU issue slots).
- Arbitrates issue slots round-robin.
- Tags each issued operation with its requester index.
- Routes each result back through a per-requester one-entry response register with valid/ready handshake.
- Sits between the core's FP dispatch ports and the single fmul instance.

Parameters:
NREQ, 4, number of requesters (2..8)
LAT, 8, multiplier latency in cycles from issue to result
W, 32, operand/result width (IEEE-754 single)

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
req_valid  in  NREQ  requester i has an operation
req_ready  out  NREQ  requester i granted this cycle (handshake = valid && ready)
req_x1  in  NREQ*W  operand 1, requester i at [i*W +: W]
req_x2  in  NREQ*W  operand 2, same packing
rsp_valid  out  NREQ  result held for requester i
rsp_ready  in  NREQ  requester i consumes result
rsp_y  out  NREQ*W  result for requester i, same packing
fmul_issue  out  1  operation presented to multiplier this cycle
fmul_x1  out  W  operand 1 to multiplier
fmul_x2  out  W  operand 2 to multiplier
fmul_y  in  W  multiplier result, valid exactly LAT cycles after issue
idle  out  1  no operation in flight and no result pending

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, port rst.
- Reset state:
  - ptr=0; busy[]=0; tag pipeline valid bits=0.
  - rsp_valid=0, rsp_y=0.
  - Combinational outputs under reset: req_ready=0, fmul_issue=0, fmul_x1=fmul_x2=0, idle=1.
  - rst asserted mid-operation discards all in-flight and pending results. fmul_y arriving afterwards is ignored.
- Eligibility and grant:
  - Requester i is eligible when req_valid[i] && !busy[i] && !rst.
  - At most one grant per cycle: the first eligible index at or after ptr, searching upward and wrapping NREQ-1 -> 0.
  - req_ready is combinational, one-hot or zero.
- Issue:
  - fmul_issue = |req_ready.
  - fmul_x1/fmul_x2 = granted requester's operands (combinational mux); 0 when no grant.
- Pointer: on grant to i, ptr <= (i+1) mod NREQ. With no grant, ptr holds.
- busy:
  - busy[i] set on grant.
  - busy[i] cleared in the cycle after the rsp handshake (rsp_valid[i] && rsp_ready[i]).
  - Hence one outstanding operation per requester. Earliest re-grant is the cycle after the response handshake, never the same cycle.
- Tag pipeline:
  - LAT stages of {valid, index}. Stage 0 is loaded on issue; the pipeline shifts every cycle and never stalls.
  - When the last stage is valid (cycle t+LAT for issue at cycle t), fmul_y is captured: rsp_y[idx] <= fmul_y and rsp_valid[idx] <= 1, visible from cycle t+LAT+1.
  - Issue-to-rsp_valid latency is LAT+1.
- Response register: rsp_valid[i] stays high and rsp_y[i] stays stable until the handshake; rsp_valid[i] falls the following cycle. rsp_y keeps its last value after consumption.
- No collisions: busy guarantees a capture never hits an occupied response register. A capture while rsp_valid[idx]=1 is a design error (assertion in the bench).
- Throughput: one issue per cycle overall when eligible requesters exist.
- Simultaneous events:
  - Grant and capture for different requesters in the same cycle are independent.
  - Capture for i and handshake for j≠i in the same cycle are independent.
- idle = !(|busy).
- Arithmetic: the block never inspects operand or result bits. All numeric behaviour belongs to the multiplier.

Decomposition:
- Package fpu_pkg holds:
  - FLOAT_W=32, FMUL_LAT=8.
  - Typedef float_t (logic [31:0]).
  - Typedef tag_t, a struct {valid, idx}.
  - Function clog2-based IDX_W.
- One sub-module, rr_arbiter (parameter N): inputs eligible vector and ptr; outputs one-hot grant and next_ptr; purely combinational.
- Tag pipeline, busy flags and response registers stay in fmul_sched.

Test Plan:
1. Single request: NREQ=4, LAT=8, req_valid=0001, x1=3F800000, x2=40000000 at cycle 0 -> req_ready=0001 at cycle 0; fmul_x1/x2 match; rsp_valid[0]=1 at cycle 9; rsp_y[0]=40000000 (model returns product).
2. All four requesters valid continuously from reset -> grants 0,1,2,3 on cycles 0-3, then no grants (all busy); results appear at cycles 9-12 in order on the correct lanes.
3. Round-robin fairness: after ptr=2, req_valid=1011 -> grant order 3,0,1; ptr wraps 3 -> 0.
4. Back-pressure: rsp_ready[1]=0 for 20 cycles after result -> rsp_valid[1] and rsp_y[1] held stable; req_ready[1] stays 0 despite req_valid[1]=1; re-grant occurs the cycle after the handshake.
5. Reset mid-flight: issue on requesters 0 and 2, assert rst at cycle 4 for 1 cycle -> all rsp_valid remain 0 through cycle 20; idle=1; the next request issues normally with latency LAT+1.
6. Simultaneous: capture for lane 0, handshake on lane 3 and new grant to lane 1 in the same cycle -> all three take effect; no lane corruption (scoreboard checks every result against its tag).
